// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix scanner.
// Scan phase encoding, parameter legality check and the brightness mapping
// (optional gamma curve, enabled in the top by LED_MATRIX_GAMMA_EN).
package led_matrix_pkg;

    typedef enum logic {
        BLANK  = 1'b0,
        ACTIVE = 1'b1
    } scan_phase_t;

    // The blanking gap must leave room in the slot, and the lit part of the
    // slot must hold a whole number of PWM periods.
    function automatic bit timing_legal(int unsigned slot_cycles,
                                        int unsigned blank_cycles,
                                        int unsigned bright_w);
        if (blank_cycles >= slot_cycles) return 1'b0;
        return ((slot_cycles - blank_cycles) % (32'd1 << bright_w)) == 32'd0;
    endfunction

    // Latched brightness -> effective PWM threshold. The gamma curve squares
    // the level; full scale always stays full scale.
    function automatic int unsigned bright_map(int unsigned b,
                                               int unsigned bright_w,
                                               bit          gamma_en);
        int unsigned full;
        full = (32'd1 << bright_w) - 32'd1;
        if (!gamma_en || b == full) return b;
        return (b * b) >> bright_w;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Slot and column counters for the LED matrix scanner.
// Emits the scan phase, the current column, the PWM index inside the lit
// part of the slot, and a strobe marking the frame boundary cycle.
import led_matrix_pkg::*;

module led_scan_timer #(
    parameter int COLS         = 4,
    parameter int SLOT_CYCLES  = 3000,
    parameter int BLANK_CYCLES = 40,
    parameter int BRIGHT_W     = 4,
    parameter int CW           = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                clk12MHz,
    input  logic                rst,
    output scan_phase_t         phase,
    output logic [CW-1:0]       col,
    output logic [BRIGHT_W-1:0] pwm_idx,
    output logic                boundary
);

    localparam int SCW = $clog2(SLOT_CYCLES);

    logic [SCW-1:0] slot_cnt;

    // Advance the slot counter every cycle; wrap it and step the column.
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            slot_cnt <= '0;
            col      <= '0;
        end else if (slot_cnt == SCW'(SLOT_CYCLES - 1)) begin
            slot_cnt <= '0;
            col      <= (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
        end else begin
            slot_cnt <= slot_cnt + SCW'(1);
        end
    end

    // Decode phase, PWM index (low bits of the offset into the lit window)
    // and the frame boundary from the counters.
    always_comb begin
        phase    = (slot_cnt < SCW'(BLANK_CYCLES)) ? BLANK : ACTIVE;
        pwm_idx  = BRIGHT_W'(slot_cnt - SCW'(BLANK_CYCLES));
        boundary = (slot_cnt == '0) && (col == '0);
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered multiplexed LED matrix driver.
// Writers fill the back buffer; a requested swap is applied only at a frame
// boundary so a frame is never torn. Brightness is latched per frame.
// Optional feature: define LED_MATRIX_GAMMA_EN to apply a squared gamma
// curve to the latched brightness.
import led_matrix_pkg::*;

module led_matrix_scanner #(
    parameter int COLS         = 4,
    parameter int ROWS         = 8,
    parameter int SLOT_CYCLES  = 3000,
    parameter int BLANK_CYCLES = 40,
    parameter int BRIGHT_W     = 4,
    parameter int CW           = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                clk12MHz,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_col,
    input  logic [ROWS-1:0]     wr_data,
    input  logic                swap_req,
    output logic                swap_pending,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic                frame_start,
    output logic [ROWS-1:0]     led,
    output logic [COLS-1:0]     lcol
);

`ifdef LED_MATRIX_GAMMA_EN
    localparam bit GAMMA_EN = 1'b1;
`else
    localparam bit GAMMA_EN = 1'b0;
`endif

    if (!timing_legal(SLOT_CYCLES, BLANK_CYCLES, BRIGHT_W)) begin : g_bad_timing
        $error("led_matrix_scanner: BLANK_CYCLES must be < SLOT_CYCLES and (SLOT_CYCLES-BLANK_CYCLES) a multiple of 2**BRIGHT_W");
    end

    typedef logic [COLS-1:0][ROWS-1:0] fb_t;

    scan_phase_t         phase;
    logic [CW-1:0]       col;
    logic [BRIGHT_W-1:0] pwm_idx;
    logic                boundary;

    fb_t                 front, back, front_n, back_n;
    logic [BRIGHT_W-1:0] bright_lat, bright_n, bright_eff;
    logic                pend_n;
    logic                wr_ok;
    logic                lit;

    led_scan_timer #(
        .COLS         (COLS),
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BRIGHT_W     (BRIGHT_W),
        .CW           (CW)
    ) u_timer (
        .clk12MHz (clk12MHz),
        .rst      (rst),
        .phase    (phase),
        .col      (col),
        .pwm_idx  (pwm_idx),
        .boundary (boundary)
    );

    // A column index beyond the matrix can only occur when COLS is not a
    // power of two; such writes are dropped.
    if (COLS == (1 << CW)) begin : g_wr_full
        assign wr_ok = wr_en;
    end else begin : g_wr_range
        assign wr_ok = wr_en && (int'(wr_col) < COLS);
    end

    // Next buffer/brightness/swap state. The write lands in the pre-swap back
    // buffer, so a write in the boundary cycle shows up in the new frame.
    always_comb begin
        back_n   = back;
        front_n  = front;
        bright_n = bright_lat;
        pend_n   = swap_req | (swap_pending & ~boundary);
        if (wr_ok) begin
            back_n[wr_col] = wr_data;
        end
        if (boundary) begin
            bright_n = brightness;
            if (swap_pending) begin
                front_n = back_n;
                back_n  = front;
            end
        end
        bright_eff = BRIGHT_W'(bright_map(32'(bright_n), BRIGHT_W, GAMMA_EN));
        lit        = (pwm_idx < bright_eff) || (bright_eff == '1);
    end

    // Register buffers, swap flag, frame pulse and the active-low drives.
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            front        <= '0;
            back         <= '0;
            bright_lat   <= '0;
            swap_pending <= 1'b0;
            frame_start  <= 1'b0;
            led          <= '1;
            lcol         <= '1;
        end else begin
            front        <= front_n;
            back         <= back_n;
            bright_lat   <= bright_n;
            swap_pending <= pend_n;
            frame_start  <= boundary;
            if (phase == ACTIVE) begin
                lcol <= ~(COLS'(1) << col);
                led  <= lit ? ~front_n[col] : '1;
            end else begin
                lcol <= '1;
                led  <= '1;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Testbench for led_matrix_scanner (COLS=4, ROWS=8, SLOT=20, BLANK=4, BRIGHT_W=4).
// The reference model derives column/slot position from a cycle count since
// reset and applies the display, write and swap rules directly.
module tb_led_matrix_scanner;

    localparam int COLS  = 4;
    localparam int ROWS  = 8;
    localparam int SLOT  = 20;
    localparam int BLANK = 4;
    localparam int BW    = 4;
    localparam int FRAME = SLOT * COLS;

    logic            clk12MHz = 1'b0;
    logic            rst = 1'b1;
    logic            wr_en = 1'b0;
    logic [1:0]      wr_col = '0;
    logic [ROWS-1:0] wr_data = '0;
    logic            swap_req = 1'b0;
    logic [BW-1:0]   brightness = '0;
    logic            swap_pending;
    logic            frame_start;
    logic [ROWS-1:0] led;
    logic [COLS-1:0] lcol;

    led_matrix_scanner #(
        .COLS(COLS), .ROWS(ROWS), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .BRIGHT_W(BW)
    ) dut (
        .clk12MHz     (clk12MHz),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_col       (wr_col),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .brightness   (brightness),
        .frame_start  (frame_start),
        .led          (led),
        .lcol         (lcol)
    );

    always #5 clk12MHz = ~clk12MHz;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         mt;
    int         last_pos;
    int         mbright;
    bit         mpend;
    logic [7:0] mfront[COLS];
    logic [7:0] mback[COLS];
    logic [7:0] exp_led;
    logic [3:0] exp_lcol;
    logic       exp_fs;
    logic       exp_pend;

    function automatic int beff(int b);
`ifdef LED_MATRIX_GAMMA_EN
        if (b == 15) return 15;
        return (b * b) >> BW;
`else
        return b;
`endif
    endfunction

    // Advance the model by one cycle with the current inputs, then clock the DUT.
    task automatic tick();
        int slot, c, a;
        logic [7:0] tmp[COLS];
        if (rst) begin
            mt = 0; last_pos = -1; mbright = 0; mpend = 0;
            for (int i = 0; i < COLS; i++) begin mfront[i] = '0; mback[i] = '0; end
            exp_led = 8'hFF; exp_lcol = 4'hF; exp_fs = 1'b0; exp_pend = 1'b0;
        end else begin
            slot = mt % SLOT;
            c = (mt / SLOT) % COLS;
            last_pos = mt % FRAME;
            if (slot < BLANK) begin
                exp_led = 8'hFF; exp_lcol = 4'hF;
            end else begin
                a = (slot - BLANK) % 16;
                exp_lcol = ~(4'b0001 << c);
                exp_led = (beff(mbright) == 15 || a < beff(mbright)) ? ~mfront[c] : 8'hFF;
            end
            exp_fs = (last_pos == 0);
            if (wr_en) mback[wr_col] = wr_data;
            if (last_pos == 0) begin
                mbright = int'(brightness);
                if (mpend) begin
                    tmp = mfront; mfront = mback; mback = tmp;
                end
            end
            mpend = swap_req || (mpend && last_pos != 0);
            exp_pend = mpend;
            mt++;
        end
        @(posedge clk12MHz);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (led !== 8'hFF) begin errors++; $display("FAIL reset_led got=%h want=ff", led); end
        checks++; if (lcol !== 4'hF) begin errors++; $display("FAIL reset_lcol got=%h want=f", lcol); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b want=0", frame_start); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_pend got=%b want=0", swap_pending); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        wr_en = 1; wr_col = 0; wr_data = 8'hA5; swap_req = 1; brightness = 15;
        for (int k = 0; k < 160; k++) begin
            tick();
            wr_en = 0; swap_req = 0;
            checks++;
            if ({led, lcol, frame_start, swap_pending} !== {exp_led, exp_lcol, exp_fs, exp_pend}) begin
                errors++;
                $display("FAIL basic_model k=%0d got led=%h lcol=%h fs=%b pend=%b want led=%h lcol=%h fs=%b pend=%b", k, led, lcol, frame_start, swap_pending, exp_led, exp_lcol, exp_fs, exp_pend);
            end
            if (k >= 84 && k < 100) begin
                checks++;
                if (lcol !== 4'b1110 || led !== 8'h5A) begin errors++; $display("FAIL basic_slot0 k=%0d got led=%h lcol=%b want led=5a lcol=1110", k, led, lcol); end
            end
            if (k >= 80 && k < 84) begin
                checks++;
                if (lcol !== 4'hF || led !== 8'hFF) begin errors++; $display("FAIL basic_blank k=%0d got led=%h lcol=%h want led=ff lcol=f", k, led, lcol); end
            end
        end
    endtask

    task automatic test_pwm();
        brightness = 4;
        for (int k = 0; k < 160; k++) begin
            tick();
            checks++;
            if ({led, lcol, frame_start, swap_pending} !== {exp_led, exp_lcol, exp_fs, exp_pend}) begin
                errors++;
                $display("FAIL pwm_model k=%0d got led=%h lcol=%h want led=%h lcol=%h", k, led, lcol, exp_led, exp_lcol);
            end
            if (mbright == 4 && last_pos >= 4 && last_pos < 20) begin
                checks++;
                if (led !== ((last_pos - 4 < 4) ? 8'h5A : 8'hFF)) begin
                    errors++; $display("FAIL pwm4 a=%0d got led=%h want=%h", last_pos - 4, led, (last_pos - 4 < 4) ? 8'h5A : 8'hFF);
                end
            end
        end
        brightness = 0;
        for (int k = 0; k < 160; k++) begin
            tick();
            if (mbright == 0) begin
                checks++;
                if (led !== 8'hFF) begin errors++; $display("FAIL pwm0 k=%0d got led=%h want=ff", k, led); end
            end
        end
    endtask

    task automatic test_no_tear();
        int fs_count = 0;
        brightness = 15;
        for (int k = 0; k < 240; k++) begin
            wr_en = (k == 0); wr_col = 2; wr_data = 8'hFF;
            swap_req = (k == 100);
            tick();
            if (frame_start === 1'b1) fs_count++;
            checks++;
            if ({led, lcol, frame_start, swap_pending} !== {exp_led, exp_lcol, exp_fs, exp_pend}) begin
                errors++;
                $display("FAIL tear_model k=%0d got led=%h lcol=%h fs=%b pend=%b want led=%h lcol=%h fs=%b pend=%b", k, led, lcol, frame_start, swap_pending, exp_led, exp_lcol, exp_fs, exp_pend);
            end
            if (k > 100 && k < 160) begin
                checks++;
                if (swap_pending !== 1'b1) begin errors++; $display("FAIL tear_pending k=%0d got=%b want=1", k, swap_pending); end
            end
            if (k == 160) begin
                checks++;
                if (swap_pending !== 1'b0) begin errors++; $display("FAIL tear_pend_clear got=%b want=0", swap_pending); end
            end
            if (k >= 44 && k < 60) begin
                checks++;
                if (led !== 8'hFF) begin errors++; $display("FAIL tear_old_slot2 k=%0d got led=%h want=ff", k, led); end
            end
            if (k >= 204 && k < 220) begin
                checks++;
                if (led !== 8'h00 || lcol !== 4'b1011) begin errors++; $display("FAIL tear_new_slot2 k=%0d got led=%h lcol=%b want led=00 lcol=1011", k, led, lcol); end
            end
        end
        wr_en = 0; swap_req = 0;
        checks++;
        if (fs_count != 3) begin errors++; $display("FAIL frame_start_count got=%0d want=3", fs_count); end
    endtask

    task automatic test_boundary_write();
        brightness = 15;
        swap_req = 1;
        tick();
        swap_req = 0;
        for (int g = 0; g < 2 * FRAME && (mt % FRAME) != 0; g++) begin
            tick();
            checks++;
            if ({led, lcol, frame_start, swap_pending} !== {exp_led, exp_lcol, exp_fs, exp_pend}) begin
                errors++; $display("FAIL bwr_model got led=%h lcol=%h pend=%b want led=%h lcol=%h pend=%b", led, lcol, swap_pending, exp_led, exp_lcol, exp_pend);
            end
        end
        checks++;
        if (swap_pending !== 1'b1) begin errors++; $display("FAIL bwr_pending got=%b want=1", swap_pending); end
        wr_en = 1; wr_col = 1; wr_data = 8'h0F;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            wr_en = 0;
            checks++;
            if ({led, lcol, frame_start, swap_pending} !== {exp_led, exp_lcol, exp_fs, exp_pend}) begin
                errors++; $display("FAIL bwr_model2 k=%0d got led=%h lcol=%h want led=%h lcol=%h", k, led, lcol, exp_led, exp_lcol);
            end
            if (k >= 24 && k < 40) begin
                checks++;
                if (led !== 8'hF0 || lcol !== 4'b1101) begin errors++; $display("FAIL bwr_slot1 k=%0d got led=%h lcol=%b want led=f0 lcol=1101", k, led, lcol); end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_col = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
            swap_req = ($urandom_range(0, 15) == 0);
            brightness = 4'($urandom);
            tick();
            checks++;
            if ({led, lcol, frame_start, swap_pending} !== {exp_led, exp_lcol, exp_fs, exp_pend}) begin
                errors++;
                $display("FAIL random_model k=%0d got led=%h lcol=%h fs=%b pend=%b want led=%h lcol=%h fs=%b pend=%b", k, led, lcol, frame_start, swap_pending, exp_led, exp_lcol, exp_fs, exp_pend);
            end
        end
        wr_en = 0; swap_req = 0;
    endtask

    task automatic test_mid_reset();
        brightness = 15;
        for (int g = 0; g < 2 * FRAME && (mt % FRAME) != 49; g++) tick();
        swap_req = 1;
        tick();
        swap_req = 0;
        checks++;
        if (swap_pending !== 1'b1) begin errors++; $display("FAIL mrst_pre_pend got=%b want=1", swap_pending); end
        rst = 1;
        tick();
        checks++; if (lcol !== 4'hF) begin errors++; $display("FAIL mrst_lcol got=%h want=f", lcol); end
        checks++; if (led !== 8'hFF) begin errors++; $display("FAIL mrst_led got=%h want=ff", led); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL mrst_pend got=%b want=0", swap_pending); end
        rst = 0;
        tick();
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL mrst_fs got=%b want=1", frame_start); end
        for (int k = 0; k < FRAME; k++) begin
            tick();
            checks++;
            if (led !== 8'hFF || frame_start !== exp_fs) begin errors++; $display("FAIL mrst_blank k=%0d got led=%h fs=%b want led=ff fs=%b", k, led, frame_start, exp_fs); end
        end
    endtask

`ifdef LED_MATRIX_GAMMA_EN
    task automatic test_gamma();
        wr_en = 1; wr_col = 0; wr_data = 8'hFF; swap_req = 1; brightness = 8;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            wr_en = 0; swap_req = 0;
            if (mbright == 8 && mfront[0] == 8'hFF && last_pos >= 4 && last_pos < 20) begin
                checks++;
                if (led !== ((last_pos - 4 < 4) ? 8'h00 : 8'hFF)) begin errors++; $display("FAIL gamma8 a=%0d got led=%h", last_pos - 4, led); end
            end
        end
        brightness = 15;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (mbright == 15 && last_pos >= 4 && last_pos < 20) begin
                checks++;
                if (led !== 8'h00) begin errors++; $display("FAIL gamma15 a=%0d got led=%h want=00", last_pos - 4, led); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_pwm();
        test_no_tear();
        test_boundary_write();
        test_random();
        test_mid_reset();
`ifdef LED_MATRIX_GAMMA_EN
        test_gamma();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
